// File: rtl/dmem_responder_if.sv
// D_MEM request/response bundle between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        wen;       // 0 = store, 1 = load
  logic [3:0]  be;
  logic [31:0] di;
  logic [2:0]  lfunct;
  logic        resp_valid;
  logic [31:0] dout;
  logic        err;

  modport master (
    output req_valid, addr, wen, be, di, lfunct,
    input  req_ready, resp_valid, dout, err
  );

  modport slave (
    input  req_valid, addr, wen, be, di, lfunct,
    output req_ready, resp_valid, dout, err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM with store byte steering and load extension, fixed LATENCY.
// Optional macro DMEM_MISALIGN_TRAP_EN: flag misaligned accesses via ERR instead of aligning them.
module dmem_responder #(
  parameter int DEPTH_W = 1024,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH_W);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  typedef struct packed {
    logic       ill;
    logic       mis;
    logic [1:0] off;
  } dec_t;

  // Classify an access and produce the byte offset actually used.
  function automatic dec_t decode(input logic wen, input logic [1:0] a,
                                  input logic [3:0] be, input logic [2:0] lf);
    dec_t d;
    logic half, word;
    half  = wen ? (lf[1:0] == 2'b01) : (be == 4'b0011);
    word  = wen ? (lf[1:0] == 2'b10) : (be == 4'b1111);
    d.ill = wen ? (lf == 3'b011 || lf[2:1] == 2'b11)
                : !(be == 4'b0001 || be == 4'b0011 || be == 4'b1111);
    d.mis = (half && a[0]) || (word && a != 2'b00);
    d.off = a;
`ifndef DMEM_MISALIGN_TRAP_EN
    if (half) d.off[0] = 1'b0;
    if (word) d.off    = 2'b00;
    d.mis = 1'b0;
`endif
    return d;
  endfunction

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        accept, go_resp;
  logic [31:0] addr_q, di_q;
  logic        wen_q;
  logic [3:0]  be_q;
  logic [2:0]  lf_q;
  logic [31:0] rdata;
  logic [31:0] mem [DEPTH_W];

  // With LATENCY=1 the RAM access happens on the accept edge, so use the live request.
  logic [31:0] c_addr, c_di;
  logic        c_wen;
  logic [3:0]  c_be;
  logic [2:0]  c_lf;
  dec_t        c_dec, q_dec;
  logic [3:0]  lanes;
  logic [31:0] wdata, sh, ext;
  logic [AW-1:0] c_idx;
  logic        unused_addr;

  assign c_addr = (LATENCY == 1) ? bus.addr   : addr_q;
  assign c_di   = (LATENCY == 1) ? bus.di     : di_q;
  assign c_wen  = (LATENCY == 1) ? bus.wen    : wen_q;
  assign c_be   = (LATENCY == 1) ? bus.be     : be_q;
  assign c_lf   = (LATENCY == 1) ? bus.lfunct : lf_q;
  assign c_dec  = decode(c_wen, c_addr[1:0], c_be, c_lf);
  assign q_dec  = decode(wen_q, addr_q[1:0], be_q, lf_q);
  assign c_idx  = c_addr[AW+1:2];
  assign lanes  = 4'(c_be << c_dec.off);
  assign wdata  = c_di << {c_dec.off, 3'b000};
  assign unused_addr = ^c_addr[31:AW+2];

  assign accept = bus.req_valid & bus.req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept)                         cnt <= 4'(LATENCY - 2);
      else if (state == S_WAIT && cnt != 0) cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE, S_RESP: state_nxt = accept ? ((LATENCY == 1) ? S_RESP : S_WAIT) : S_IDLE;
      S_WAIT:         state_nxt = (cnt == 0) ? S_RESP : S_WAIT;
      default:        state_nxt = S_IDLE;
    endcase
    go_resp = (state_nxt == S_RESP) && (state == S_WAIT || accept);
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= bus.addr;
      di_q   <= bus.di;
      wen_q  <= bus.wen;
      be_q   <= bus.be;
      lf_q   <= bus.lfunct;
    end
  end

  // RAM commits/reads on the edge that enters RESP; reset kills the pending access.
  always_ff @(posedge clk) begin
    if (!rst && go_resp) begin
      if (c_wen) rdata <= mem[c_idx];
      else if (!c_dec.ill && !c_dec.mis)
        for (int i = 0; i < 4; i++)
          if (lanes[i]) mem[c_idx][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign sh = rdata >> {q_dec.off, 3'b000};
  always_comb begin
    case (lf_q)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b101:  ext = {16'd0, sh[15:0]};
      default: ext = sh;
    endcase
  end

  always_comb begin
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bus.err        = 1'b0;
    bus.dout       = '0;
    if (!rst) begin
      bus.req_ready = (state != S_WAIT);
      if (state == S_RESP) begin
        bus.resp_valid = 1'b1;
        bus.err        = q_dec.ill | q_dec.mis;
        if (wen_q && !(q_dec.ill | q_dec.mis)) bus.dout = ext;
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: reset, store/load extension, errors, back-to-back, reset abort.
module tb_dmem_responder;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if bus();
  dmem_responder #(.DEPTH_W(1024), .LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One request; checks response latency; inputs are scrambled after accept.
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [3:0] b,
                      input logic [31:0] d, input logic [2:0] f,
                      output logic [31:0] q, output logic e);
    int n;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.wen = w; bus.addr = a; bus.be = b; bus.di = d; bus.lfunct = f;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) check({tag, ":ready_timeout"}, 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    bus.req_valid = 1'b0; bus.wen = ~w; bus.addr = ~a; bus.be = 4'hF; bus.di = ~d; bus.lfunct = 3'b010;
    n = 1;
    while (!bus.resp_valid && n < 20) begin @(negedge clk); n++; end
    check({tag, ":lat"}, 32'(n), 32'(LAT));
    q = bus.dout;
    e = bus.err;
  endtask

  task automatic st(input string tag, input logic [31:0] a, input logic [3:0] b,
                    input logic [31:0] d, input logic exp_err);
    logic [31:0] q; logic e;
    xact(tag, 1'b0, a, b, d, 3'b000, q, e);
    check({tag, ":err"}, 32'(e), 32'(exp_err));
  endtask

  task automatic ld(input string tag, input logic [31:0] a, input logic [2:0] f,
                    input logic [31:0] exp, input logic exp_err);
    logic [31:0] q; logic e;
    xact(tag, 1'b1, a, 4'h0, 32'h0, f, q, e);
    check({tag, ":dout"}, q, exp);
    check({tag, ":err"}, 32'(e), 32'(exp_err));
  endtask

  logic        mon_en = 1'b0;
  int          mon_n;
  logic [31:0] mon_d [8];
  always @(negedge clk) begin
    if (!mon_en) mon_n <= 0;
    else if (bus.resp_valid) begin
      if (mon_n < 8) mon_d[mon_n] <= bus.dout;
      mon_n <= mon_n + 1;
    end
  end

  logic [0:3]       b2b_w  = 4'b0101;
  logic [31:0]      b2b_a  [4] = '{32'h40, 32'h40, 32'h41, 32'h40};
  logic [3:0]       b2b_be [4] = '{4'hF, 4'hF, 4'h1, 4'hF};
  logic [31:0]      b2b_d  [4] = '{32'h1111_1111, 32'h0, 32'h22, 32'h0};

  initial begin
    int n;
    bus.req_valid = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.be = '0; bus.di = '0; bus.lfunct = '0;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:ready", 32'(bus.req_ready), 32'd0);
    check("rst:resp",  32'(bus.resp_valid), 32'd0);
    check("rst:dout",  bus.dout, 32'd0);
    check("rst:err",   32'(bus.err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle:ready", 32'(bus.req_ready), 32'd1);
      check("idle:resp",  32'(bus.resp_valid), 32'd0);
      check("idle:err",   32'(bus.err), 32'd0);
    end

    // word store/load
    st("t2:sw", 32'h10, 4'hF, 32'h8000_00F1, 1'b0);
    ld("t2:lw", 32'h10, 3'b010, 32'h8000_00F1, 1'b0);

    // byte store, sign/zero extension
    st("t3:sb",  32'h13, 4'h1, 32'h0000_0080, 1'b0);
    ld("t3:lb",  32'h13, 3'b000, 32'hFFFF_FF80, 1'b0);
    ld("t3:lbu", 32'h13, 3'b100, 32'h0000_0080, 1'b0);
    ld("t3:lw",  32'h10, 3'b010, 32'h8000_00F1, 1'b0);
    ld("t3:lb0", 32'h10, 3'b000, 32'hFFFF_FFF1, 1'b0);

    // halfwords, misalignment, illegal encodings
    st("t4:sw",  32'h14, 4'hF, 32'hA5A5_5A5A, 1'b0);
    st("t4:sh",  32'h16, 4'h3, 32'h0000_1234, 1'b0);
    ld("t4:lh",  32'h16, 3'b001, 32'h0000_1234, 1'b0);
    ld("t4:lhu", 32'h16, 3'b101, 32'h0000_1234, 1'b0);
    ld("t4:lw",  32'h14, 3'b010, 32'h1234_5A5A, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
    st("t4:sh_mis", 32'h15, 4'h3, 32'h0000_BEEF, 1'b1);
    ld("t4:lw_aft", 32'h14, 3'b010, 32'h1234_5A5A, 1'b0);
    ld("t4:lh_aft", 32'h14, 3'b001, 32'h0000_5A5A, 1'b0);
    ld("t4:lw_mis", 32'h15, 3'b010, 32'h0000_0000, 1'b1);
`else
    st("t4:sh_mis", 32'h15, 4'h3, 32'h0000_BEEF, 1'b0);
    ld("t4:lw_aft", 32'h14, 3'b010, 32'h1234_BEEF, 1'b0);
    ld("t4:lh_aft", 32'h14, 3'b001, 32'hFFFF_BEEF, 1'b0);
    ld("t4:lw_mis", 32'h15, 3'b010, 32'h1234_BEEF, 1'b0);
`endif
    ld("t4:ld_ill", 32'h14, 3'b011, 32'h0000_0000, 1'b1);
    ld("t4:ld_111", 32'h14, 3'b111, 32'h0000_0000, 1'b1);
    st("t4:st_ill", 32'h14, 4'b0101, 32'hFFFF_FFFF, 1'b1);
`ifdef DMEM_MISALIGN_TRAP_EN
    ld("t4:lw_ill", 32'h14, 3'b010, 32'h1234_5A5A, 1'b0);
`else
    ld("t4:lw_ill", 32'h14, 3'b010, 32'h1234_BEEF, 1'b0);
`endif

    // back-to-back with REQ_VALID held high
    @(negedge clk);
    mon_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1; bus.wen = b2b_w[i]; bus.addr = b2b_a[i];
      bus.be = b2b_be[i]; bus.di = b2b_d[i]; bus.lfunct = 3'b010;
      n = 0;
      while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
      if (i > 0) check("t5:acc_in_resp", 32'(bus.resp_valid), 32'd1);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("t5:count", 32'(mon_n), 32'd4);
    check("t5:lw1", mon_d[1], 32'h1111_1111);
    check("t5:lw3", mon_d[3], 32'h1111_2211);
    mon_en = 1'b0;

    // reset during WAIT aborts the store
    st("t6:pre", 32'h20, 4'hF, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.wen = 1'b0; bus.addr = 32'h20; bus.be = 4'hF; bus.di = 32'hDEAD_BEEF;
    n = 0;
    while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b1;
    check("t6:rv_in_rst", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      if (bus.resp_valid) n++;
      @(negedge clk);
    end
    check("t6:no_resp", 32'(n), 32'd0);
    ld("t6:lw", 32'h20, 3'b010, 32'hCAFE_F00D, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
